// File: rtl/thor_regfile_valid_tracker.sv
// Register scoreboard for the out-of-order core: a valid bit and the youngest producer tag per
// architectural register. Decode marks registers pending, commit and branch-miss release them.
module thor_regfile_valid_tracker #(
  parameter int NREGS       = 64,
  parameter int REB_ENTRIES = 8,
  parameter int NDEC        = 2,
  parameter int NCMT        = 2,
  parameter int TW          = $clog2(REB_ENTRIES),
  parameter int RW          = $clog2(NREGS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NDEC-1:0]       dec_v_i,
  input  logic [NDEC-1:0]       dec_rfwr_i,
  input  logic [NDEC*RW-1:0]    dec_rt_i,
  input  logic [NDEC*TW-1:0]    dec_id_i,
  input  logic [NCMT-1:0]       cmt_v_i,
  input  logic [NCMT-1:0]       cmt_wr_i,
  input  logic [NCMT*RW-1:0]    cmt_tgt_i,
  input  logic [NCMT*TW-1:0]    cmt_id_i,
  input  logic                  branchmiss_i,
  input  logic [REB_ENTRIES-1:0] live_id_i,
  output logic [NREGS-1:0]      regfile_valid_o,
  output logic [NREGS*TW-1:0]   regfile_src_o,
  output logic [NREGS-1:0]      next_regfile_valid_o,
  output logic [RW:0]           pending_cnt_o
);

  logic [NREGS-1:0] valid_q, valid_d;
  logic [TW-1:0]    src_q [NREGS];
  logic [TW-1:0]    src_d [NREGS];
  logic [RW:0]      pend_q, pend_d;

  // Steps are applied in priority order: commit, then flush or decode, then r0 pinning.
  always_comb begin
    valid_d = valid_q;
    src_d   = src_q;
    pend_d  = '0;
    for (int c = 0; c < NCMT; c++) begin
      if (cmt_v_i[c] && cmt_wr_i[c] && !valid_q[cmt_tgt_i[c*RW +: RW]] &&
          src_q[cmt_tgt_i[c*RW +: RW]] == cmt_id_i[c*TW +: TW])
        valid_d[cmt_tgt_i[c*RW +: RW]] = 1'b1;
    end
    if (branchmiss_i) begin
      for (int r = 0; r < NREGS; r++) begin
        if (!valid_q[r] && !live_id_i[src_q[r]])
          valid_d[r] = 1'b1;
      end
    end else begin
      for (int d = 0; d < NDEC; d++) begin
        if (dec_v_i[d] && dec_rfwr_i[d] && dec_rt_i[d*RW +: RW] != '0) begin
          valid_d[dec_rt_i[d*RW +: RW]] = 1'b0;
          src_d[dec_rt_i[d*RW +: RW]]   = dec_id_i[d*TW +: TW];
        end
      end
    end
    valid_d[0] = 1'b1;
    src_d[0]   = '0;
    if (!rst_i) begin
      valid_d = '1;
      for (int r = 0; r < NREGS; r++) src_d[r] = '0;
    end
    for (int r = 0; r < NREGS; r++)
      pend_d = pend_d + {{RW{1'b0}}, ~valid_d[r]};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '1;
      pend_q  <= '0;
      for (int r = 0; r < NREGS; r++) src_q[r] <= '0;
    end else begin
      valid_q <= valid_d;
      pend_q  <= pend_d;
      src_q   <= src_d;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_src
    assign regfile_src_o[g*TW +: TW] = src_q[g];
  end

  assign regfile_valid_o      = valid_q;
  assign next_regfile_valid_o = valid_d;
  assign pending_cnt_o        = pend_q;

endmodule

// File: tb/tb_thor_regfile_valid_tracker.sv
// Bench for the register scoreboard: directed scenarios plus random traffic, compared every
// cycle against an array-based model of the scoreboard rules.
module tb_thor_regfile_valid_tracker;
  localparam int NREGS = 64, REB = 8, NDEC = 2, NCMT = 2, TW = 3, RW = 6;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NDEC-1:0]      dec_v, dec_rfwr;
  logic [NDEC*RW-1:0]   dec_rt;
  logic [NDEC*TW-1:0]   dec_id;
  logic [NCMT-1:0]      cmt_v, cmt_wr;
  logic [NCMT*RW-1:0]   cmt_tgt;
  logic [NCMT*TW-1:0]   cmt_id;
  logic                 branchmiss;
  logic [REB-1:0]       live_id;
  logic [NREGS-1:0]     regfile_valid, next_regfile_valid;
  logic [NREGS*TW-1:0]  regfile_src;
  logic [RW:0]          pending_cnt;

  int n_tests = 0, n_fail = 0;
  bit mv [NREGS];
  int ms [NREGS];
  bit nv [NREGS];
  int ns [NREGS];

  always #5 clk = ~clk;

  thor_regfile_valid_tracker dut (
    .clk_i(clk), .rst_i(rst),
    .dec_v_i(dec_v), .dec_rfwr_i(dec_rfwr), .dec_rt_i(dec_rt), .dec_id_i(dec_id),
    .cmt_v_i(cmt_v), .cmt_wr_i(cmt_wr), .cmt_tgt_i(cmt_tgt), .cmt_id_i(cmt_id),
    .branchmiss_i(branchmiss), .live_id_i(live_id),
    .regfile_valid_o(regfile_valid), .regfile_src_o(regfile_src),
    .next_regfile_valid_o(next_regfile_valid), .pending_cnt_o(pending_cnt)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREGS-1:0] pack_v(input bit v [NREGS]);
    logic [NREGS-1:0] p;
    for (int r = 0; r < NREGS; r++) p[r] = v[r];
    return p;
  endfunction

  function automatic logic [NREGS*TW-1:0] pack_s(input int s [NREGS]);
    logic [NREGS*TW-1:0] p;
    for (int r = 0; r < NREGS; r++) p[r*TW +: TW] = TW'(s[r]);
    return p;
  endfunction

  task automatic clr_inputs();
    rst = 1'b1; dec_v = '0; dec_rfwr = '0; dec_rt = '0; dec_id = '0;
    cmt_v = '0; cmt_wr = '0; cmt_tgt = '0; cmt_id = '0;
    branchmiss = 1'b0; live_id = '0;
  endtask

  task automatic set_dec(input int slot, input int rt, input int id);
    dec_v[slot] = 1'b1; dec_rfwr[slot] = 1'b1;
    dec_rt[slot*RW +: RW] = RW'(rt); dec_id[slot*TW +: TW] = TW'(id);
  endtask

  task automatic set_cmt(input int port, input int tgt, input int id);
    cmt_v[port] = 1'b1; cmt_wr[port] = 1'b1;
    cmt_tgt[port*RW +: RW] = RW'(tgt); cmt_id[port*TW +: TW] = TW'(id);
  endtask

  // Scoreboard rules as ordered steps over a per-register (valid, tag) table.
  task automatic model_next();
    for (int r = 0; r < NREGS; r++) begin nv[r] = mv[r]; ns[r] = ms[r]; end
    if (rst !== 1'b1) begin
      for (int r = 0; r < NREGS; r++) begin nv[r] = 1; ns[r] = 0; end
      return;
    end
    for (int c = 0; c < NCMT; c++) begin
      int t = int'(cmt_tgt[c*RW +: RW]);
      if (cmt_v[c] && cmt_wr[c] && !mv[t] && ms[t] == int'(cmt_id[c*TW +: TW])) nv[t] = 1;
    end
    if (branchmiss) begin
      for (int r = 0; r < NREGS; r++)
        if (!mv[r] && live_id[ms[r]] == 1'b0) nv[r] = 1;
    end else begin
      for (int d = 0; d < NDEC; d++) begin
        int t = int'(dec_rt[d*RW +: RW]);
        if (dec_v[d] && dec_rfwr[d] && t != 0) begin nv[t] = 0; ns[t] = int'(dec_id[d*TW +: TW]); end
      end
    end
    nv[0] = 1; ns[0] = 0;
  endtask

  function automatic int model_pending();
    int n = 0;
    for (int r = 0; r < NREGS; r++) if (!mv[r]) n++;
    return n;
  endfunction

  // Inputs are already driven; compare the bypass output mid-cycle and registered state after the edge.
  task automatic cycle();
    model_next();
    @(negedge clk);
    chk("next_valid", next_regfile_valid, pack_v(nv));
    @(posedge clk);
    for (int r = 0; r < NREGS; r++) begin mv[r] = nv[r]; ms[r] = ns[r]; end
    #1;
    chk("valid", regfile_valid, pack_v(mv));
    chk("src", regfile_src, pack_s(ms));
    chk("pending_cnt", pending_cnt, model_pending());
  endtask

  task automatic do_reset(input int n);
    clr_inputs(); rst = 1'b0;
    repeat (n) cycle();
    clr_inputs();
  endtask

  initial begin
    for (int r = 0; r < NREGS; r++) begin mv[r] = 1; ms[r] = 0; end
    clr_inputs();
    @(posedge clk); #1;

    // Reset, then a decode of r0 which must be ignored
    do_reset(2);
    chk("rst_valid", regfile_valid, {NREGS{1'b1}});
    chk("rst_pending", pending_cnt, 0);
    set_dec(0, 0, 3); cycle(); clr_inputs();
    chk("r0_valid", regfile_valid[0], 1);
    chk("r0_src", regfile_src[0 +: TW], 0);

    // Decode/commit pair on r5
    set_dec(0, 5, 2); cycle(); clr_inputs();
    chk("r5_pend", regfile_valid[5], 0);
    chk("r5_src", regfile_src[5*TW +: TW], 2);
    chk("r5_cnt", pending_cnt, 1);
    set_cmt(0, 5, 2); cycle(); clr_inputs();
    chk("r5_rel", regfile_valid[5], 1);
    chk("r5_cnt0", pending_cnt, 0);

    // Stale commit on r7
    set_dec(0, 7, 1); cycle(); clr_inputs();
    set_dec(1, 7, 4); cycle(); clr_inputs();
    set_cmt(1, 7, 1); cycle(); clr_inputs();
    chk("r7_stale_v", regfile_valid[7], 0);
    chk("r7_stale_s", regfile_src[7*TW +: TW], 4);
    set_cmt(0, 7, 4); cycle(); clr_inputs();
    chk("r7_rel", regfile_valid[7], 1);

    // Same-cycle conflicts on r9
    set_dec(0, 9, 5); set_dec(1, 9, 6); cycle(); clr_inputs();
    chk("r9_slot_src", regfile_src[9*TW +: TW], 6);
    set_cmt(0, 9, 6); set_dec(0, 9, 7); cycle(); clr_inputs();
    chk("r9_dec_over_v", regfile_valid[9], 0);
    chk("r9_dec_over_s", regfile_src[9*TW +: TW], 7);

    // Branch miss: only tag 1 survives, same-cycle decode suppressed
    do_reset(1);
    set_dec(0, 3, 1); set_dec(1, 4, 5); cycle(); clr_inputs();
    branchmiss = 1'b1; live_id = 8'b0000_0010; set_dec(0, 6, 2); cycle(); clr_inputs();
    chk("bm_r3", regfile_valid[3], 0);
    chk("bm_r4", regfile_valid[4], 1);
    chk("bm_r6", regfile_valid[6], 1);
    chk("bm_cnt", pending_cnt, 1);

    // Reset while ten registers are pending and commits are presented
    for (int i = 0; i < 5; i++) begin
      set_dec(0, 10 + 2*i, i); set_dec(1, 11 + 2*i, i + 1); cycle(); clr_inputs();
    end
    chk("pre_rst_cnt", pending_cnt, 11);
    set_cmt(0, 10, 0); set_cmt(1, 11, 1); rst = 1'b0; cycle(); clr_inputs();
    chk("mid_rst_valid", regfile_valid, {NREGS{1'b1}});
    chk("mid_rst_cnt", pending_cnt, 0);

    // Random traffic on a narrow register window to provoke conflicts
    for (int it = 0; it < 600; it++) begin
      clr_inputs();
      for (int d = 0; d < NDEC; d++) begin
        dec_v[d] = ($urandom_range(0, 3) != 0);
        dec_rfwr[d] = ($urandom_range(0, 4) != 0);
        dec_rt[d*RW +: RW] = RW'($urandom_range(0, 15));
        dec_id[d*TW +: TW] = TW'($urandom_range(0, 7));
      end
      for (int c = 0; c < NCMT; c++) begin
        int t = $urandom_range(0, 15);
        cmt_v[c] = $urandom_range(0, 1);
        cmt_wr[c] = ($urandom_range(0, 5) != 0);
        cmt_tgt[c*RW +: RW] = RW'(t);
        cmt_id[c*TW +: TW] = ($urandom_range(0, 3) != 0) ? TW'(ms[t]) : TW'($urandom_range(0, 7));
      end
      branchmiss = ($urandom_range(0, 11) == 0);
      live_id = REB'($urandom);
      rst = ($urandom_range(0, 59) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000");
    $fatal(1);
  end
endmodule

// File: doc/thor_regfile_valid_tracker.md
# thor_regfile_valid_tracker

Parametrised register-scoreboard for the Thor2022 out-of-order core. It holds, per architectural register, a valid bit and the reorder-buffer tag of the youngest in-flight producer. Registers are marked pending at decode and released when the matching producer commits. On a branch miss, every register whose producer was squashed is restored to valid. It sits between decode/rename, the reorder buffer and the commit stage, and replaces the fixed two-wide scoreboard with an N-decode / M-commit version that owns its source tags and reports scoreboard occupancy.

## Interface
- NREGS, 64, architectural registers; register 0 is hardwired valid.
- REB_ENTRIES, 8, reorder-buffer entries; TW = $clog2(REB_ENTRIES).
- NDEC, 2, decode slots per cycle; slot 0 is oldest.
- NCMT, 2, commit ports per cycle.
- RW, $clog2(NREGS), register index width.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-low.
- dec_v  in  NDEC  decode slot holds a valid decompressed instruction.
- dec_rfwr  in  NDEC  slot writes a register.
- dec_rt  in  NDEC x RW  destination register.
- dec_id  in  NDEC x TW  reorder-buffer tag of the slot.
- cmt_v  in  NCMT  commit port active.
- cmt_wr  in  NCMT  committing instruction writes a register.
- cmt_tgt  in  NCMT x RW  committed destination.
- cmt_id  in  NCMT x TW  committed tag.
- branchmiss  in  1  flush of the wrong path this cycle.
- live_id  in  REB_ENTRIES  tags that survive the flush; sampled only when branchmiss=1.
- regfile_valid  out  NREGS  registered scoreboard.
- regfile_src  out  NREGS x TW  registered producer tag per register.
- next_regfile_valid  out  NREGS  combinational next state of regfile_valid.
- pending_cnt  out  RW+1  registered count of registers with valid=0.

## Operation
- The next state is computed in a single combinational pass, in this order. Later steps override earlier ones on the same register.
  1. **Hold.** next = current.
  2. **Commit**, ports 0..NCMT-1 in order.
     - Condition: cmt_v & cmt_wr & !regfile_valid[tgt] & regfile_src[tgt]==cmt_id.
     - Action: valid[tgt]=1.
     - A tag mismatch means a younger producer exists; the register is left unchanged.
     - Commits to already-valid registers are ignored.
  3. **Flush**, only when branchmiss=1.
     - Every register with valid=0 and live_id[regfile_src]==0 becomes valid=1.
     - Its src is left unchanged (don't care).
     - A commit in the same cycle is applied first. This is harmless because both steps only set valid.
  4. **Decode**, suppressed entirely when branchmiss=1.
     - Slots are processed 0..NDEC-1.
     - Condition: dec_v & dec_rfwr & dec_rt!=0.
     - Action: valid[rt]=0 and src[rt]=dec_id.
     - If two slots target the same register, the higher slot wins (youngest producer).
     - Decode overrides a same-cycle commit to the same register.
  5. **Register 0.** Always valid=1 and src=0.
- pending_cnt is the population count of ~next_regfile_valid, registered alongside regfile_valid. Its maximum is NREGS-1.
- Out-of-range tags never occur: REB_ENTRIES must be a power of two.
- $display messages are simulation-only and have no functional effect.

## Timing
- **Reset** (rst=0 at an edge):
  - all regfile_valid=1;
  - all regfile_src=0;
  - pending_cnt=0.
  - Reset overrides every other input in that cycle.
  - next_regfile_valid reads all-ones while rst=0.
- **Latency.**
  - Decode marks a register pending one cycle after dec_v is presented.
  - Commit releases a register one cycle after cmt_v is presented.
  - next_regfile_valid shows both effects in the same cycle, for bypassing into issue.
- **Flush.** Registers are released one cycle after branchmiss. The next decode that is accepted is the first cycle with branchmiss=0.
- **Throughput.** No handshake and no back-pressure: up to NDEC decodes and NCMT commits are absorbed every cycle.
- **Reset mid-operation.** All pending state is discarded. No in-flight commit after reset affects the scoreboard, because every register is already valid.

## Test plan
- **Reset and register 0.**
  - Stimulus: hold rst=0 for 2 cycles, then decode r0 with tag 3.
  - Required: regfile_valid all-ones, pending_cnt=0, r0 stays valid with src=0.
- **Decode/commit pair.**
  - Stimulus: decode r5 with tag 2; next cycle, commit r5 with tag 2.
  - Required: r5 valid=0, src=2, pending_cnt=1; then r5 valid=1, pending_cnt=0.
- **Stale commit.**
  - Stimulus: decode r7 with tag 1, then r7 with tag 4; commit r7 with tag 1.
  - Required: r7 stays invalid with src=4. Committing tag 4 then sets valid.
- **Same-cycle conflicts.**
  - Stimulus A: decode slot 0 r9 tag 5 and slot 1 r9 tag 6.
  - Required A: src=6.
  - Stimulus B: in one cycle, commit r9 tag 6 and decode r9 tag 7.
  - Required B: r9 invalid, src=7.
- **Branch miss.**
  - Stimulus: r3 pending on tag 1, r4 pending on tag 5; branchmiss=1 with live_id=8'b0000_0010, plus a decode of r6 in the same cycle.
  - Required: r4 becomes valid, r3 stays pending, r6 is unaffected, pending_cnt=1.
- **Reset during activity.**
  - Stimulus: 10 registers pending, then rst=0 for 1 cycle together with commits.
  - Required: all valid, pending_cnt=0 on the next cycle.
